// File: rtl/sb_tx_arbiter_pkg.sv
// ============================================================================
// sb_tx_arbiter_pkg : sideband message types and arbiter state encoding
// Revision: 1.0
// ============================================================================
`default_nettype none

package sb_tx_arbiter_pkg;

    typedef enum logic [7:0] {
        MSG_NONE                   = 8'h00,
        SBINIT_out_of_reset        = 8'h01,
        SBINIT_done_req            = 8'h02,
        SBINIT_done_resp           = 8'h03,
        MBINIT_PARAM_config_req    = 8'h10,
        MBINIT_PARAM_config_resp   = 8'h11,
        MBTRAIN_VALVREF_start_req  = 8'h20,
        MBTRAIN_VALVREF_start_resp = 8'h21
    } msg_num_t;

    typedef enum logic [4:0] {
        OPC_NONE       = 5'h00,
        OPC_MSG_NODATA = 5'h12,
        OPC_MSG_DATA   = 5'h1B
    } opcode_t;

    typedef struct packed {
        msg_num_t    msg_num;
        opcode_t     opcode;
        logic [15:0] msg_info;
    } SB_msg_t;

    typedef enum logic [1:0] {
        ARB_IDLE        = 2'd0,
        ARB_WAIT_ACCEPT = 2'd1,
        ARB_WAIT_DONE   = 2'd2
    } sb_arb_state_t;

    function automatic SB_msg_t reset_SB_msg();
        SB_msg_t m;
        m.msg_num  = MSG_NONE;
        m.opcode   = OPC_NONE;
        m.msg_info = '0;
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sb_rr_picker.sv
// ============================================================================
// sb_rr_picker : combinational round-robin picker, first set bit from ptr_i
// Revision: 1.0
// ============================================================================
`default_nettype none

module sb_rr_picker #(
    parameter int  N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] grant_o,
    output logic             any_valid_o
);

    logic [IDX_W:0] w_idx;
    logic           w_found;

    always_comb begin
        grant_o = ptr_i;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // Wrap explicitly so non-power-of-two N_REQ stays in range
            w_idx = {1'b0, ptr_i} + (IDX_W+1)'(k);
            if (w_idx >= (IDX_W+1)'(N_REQ)) begin
                w_idx = w_idx - (IDX_W+1)'(N_REQ);
            end
            if (!w_found && req_i[w_idx[IDX_W-1:0]]) begin
                grant_o = w_idx[IDX_W-1:0];
                w_found = 1'b1;
            end
        end
    end

    assign any_valid_o = |req_i;

endmodule

`default_nettype wire

// File: rtl/sb_tx_arbiter.sv
// ============================================================================
// sb_tx_arbiter : round-robin sharing of the sideband TX serializer
// Revision: 1.0
// ============================================================================
`default_nettype none

module sb_tx_arbiter
    import sb_tx_arbiter_pkg::*;
#(
    parameter int  N_REQ          = 4,
    parameter int  ACCEPT_TIMEOUT = 16,
    localparam int CNT_W          = $clog2(ACCEPT_TIMEOUT+1),
    localparam int IDX_W          = $clog2(N_REQ)
) (
    input  logic                   clk_100MHz,
    input  logic                   reset,
    input  logic                   enable_i,
    input  logic                   flush_i,
    input  SB_msg_t [N_REQ-1:0]    req_msg_i,
    input  logic [N_REQ-1:0][63:0] req_data_i,
    input  logic [N_REQ-1:0]       req_valid_i,
    output logic [N_REQ-1:0]       req_pending_o,
    output logic [N_REQ-1:0]       req_done_o,
    output logic [N_REQ-1:0]       req_overwrite_o,
    output SB_msg_t                SB_TX_msg_o,
    output logic [63:0]            SB_TX_dataBus_o,
    output logic                   SB_TX_msg_valid_o,
    input  logic                   SB_TX_msg_sendNextFlag_i,
    output logic                   issue_timeout_o
);

    sb_arb_state_t            state_q, state_d;
    logic [N_REQ-1:0]         full_q, full_d;
    SB_msg_t [N_REQ-1:0]      slot_msg_q, slot_msg_d;
    logic [N_REQ-1:0][63:0]   slot_data_q, slot_data_d;
    logic [IDX_W-1:0]         grant_q, grant_d;
    logic [IDX_W-1:0]         rr_q, rr_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     flushed_q, flushed_d;
    SB_msg_t                  msg_q, msg_d;
    logic [63:0]              data_q, data_d;
    logic                     valid_q, valid_d;
    logic [N_REQ-1:0]         ovw_q, ovw_d;
    logic                     to_q, to_d;

    logic [IDX_W-1:0]         w_pick;
    logic                     w_any;
    logic [IDX_W:0]           w_pick_inc;
    logic [IDX_W-1:0]         w_rr_next;
    logic [CNT_W-1:0]         w_cnt_inc;
    logic                     w_issue;
    logic [N_REQ-1:0]         w_grant_oh;

    sb_rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req_i       (full_q),
        .ptr_i       (rr_q),
        .grant_o     (w_pick),
        .any_valid_o (w_any)
    );

    assign w_pick_inc = {1'b0, w_pick} + (IDX_W+1)'(1);
    assign w_rr_next  = (w_pick_inc == (IDX_W+1)'(N_REQ)) ? '0 : w_pick_inc[IDX_W-1:0];
    assign w_cnt_inc  = cnt_q + CNT_W'(1);
    assign w_issue    = (state_q == ARB_IDLE) && enable_i && SB_TX_msg_sendNextFlag_i
                        && w_any && !flush_i;

    always_comb begin
        w_grant_oh          = '0;
        w_grant_oh[grant_q] = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        full_d      = full_q;
        slot_msg_d  = slot_msg_q;
        slot_data_d = slot_data_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        flushed_d   = flushed_q;
        msg_d       = msg_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        ovw_d       = '0;
        to_d        = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (w_issue) begin
                    valid_d        = 1'b1;
                    msg_d          = slot_msg_q[w_pick];
                    data_d         = slot_data_q[w_pick];
                    full_d[w_pick] = 1'b0;
                    grant_d        = w_pick;
                    rr_d           = w_rr_next;
                    cnt_d          = '0;
                    flushed_d      = 1'b0;
                    state_d        = ARB_WAIT_ACCEPT;
                end
            end
            ARB_WAIT_ACCEPT: begin
                if (!SB_TX_msg_sendNextFlag_i) begin
                    state_d = ARB_WAIT_DONE;
                    cnt_d   = '0;
                end else if (w_cnt_inc == CNT_W'(ACCEPT_TIMEOUT)) begin
                    to_d    = 1'b1;
                    state_d = ARB_IDLE;
                    cnt_d   = '0;
                    // A refilled slot holds a newer message, so the lost one is dropped
                    if (!flushed_q && !full_q[grant_q]) begin
                        full_d[grant_q]      = 1'b1;
                        slot_msg_d[grant_q]  = msg_q;
                        slot_data_d[grant_q] = data_q;
                    end
                end else begin
                    cnt_d = w_cnt_inc;
                end
            end
            ARB_WAIT_DONE: begin
                if (SB_TX_msg_sendNextFlag_i) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        if (flush_i && (state_q != ARB_IDLE)) begin
            flushed_d = 1'b1;
        end

        // Captures come last so they win over both issue-clear and restore
        if (flush_i) begin
            full_d = '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid_i[i]) begin
                    if (full_q[i] && !(w_issue && (w_pick == IDX_W'(i)))) begin
                        ovw_d[i] = 1'b1;
                    end
                    full_d[i]      = 1'b1;
                    slot_msg_d[i]  = req_msg_i[i];
                    slot_data_d[i] = req_data_i[i];
                end
            end
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            full_q      <= '0;
            slot_msg_q  <= '0;
            slot_data_q <= '0;
            grant_q     <= '0;
            rr_q        <= '0;
            cnt_q       <= '0;
            flushed_q   <= 1'b0;
            msg_q       <= reset_SB_msg();
            data_q      <= '0;
            valid_q     <= 1'b0;
            ovw_q       <= '0;
            to_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            slot_msg_q  <= slot_msg_d;
            slot_data_q <= slot_data_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            flushed_q   <= flushed_d;
            msg_q       <= msg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            ovw_q       <= ovw_d;
            to_q        <= to_d;
        end
    end

    assign req_pending_o     = full_q | ((state_q != ARB_IDLE) ? w_grant_oh : '0);
    assign req_done_o        = (!reset && (state_q == ARB_WAIT_DONE) && SB_TX_msg_sendNextFlag_i)
                               ? w_grant_oh : '0;
    assign req_overwrite_o   = ovw_q;
    assign SB_TX_msg_o       = msg_q;
    assign SB_TX_dataBus_o   = data_q;
    assign SB_TX_msg_valid_o = valid_q;
    assign issue_timeout_o   = to_q;

endmodule

`default_nettype wire

// File: tb/tb_sb_tx_arbiter.sv
// ============================================================================
// tb_sb_tx_arbiter : directed self-checking bench for sb_tx_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sb_tx_arbiter;
    import sb_tx_arbiter_pkg::*;

    localparam int N = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic               flush;
    logic               flag;
    SB_msg_t [N-1:0]    req_msg;
    logic [N-1:0][63:0] req_data;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       pending;
    logic [N-1:0]       done;
    logic [N-1:0]       ovw;
    SB_msg_t            tx_msg;
    logic [63:0]        tx_data;
    logic               tx_valid;
    logic               timeout;

    int checks = 0;
    int errors = 0;

    SB_msg_t m0, m1, m2, m3, mb, mc, mt;

    always #5 clk = ~clk;

    sb_tx_arbiter #(
        .N_REQ          (N),
        .ACCEPT_TIMEOUT (16)
    ) dut (
        .clk_100MHz               (clk),
        .reset                    (reset),
        .enable_i                 (enable),
        .flush_i                  (flush),
        .req_msg_i                (req_msg),
        .req_data_i               (req_data),
        .req_valid_i              (req_valid),
        .req_pending_o            (pending),
        .req_done_o               (done),
        .req_overwrite_o          (ovw),
        .SB_TX_msg_o              (tx_msg),
        .SB_TX_dataBus_o          (tx_data),
        .SB_TX_msg_valid_o        (tx_valid),
        .SB_TX_msg_sendNextFlag_i (flag),
        .issue_timeout_o          (timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic SB_msg_t mk(msg_num_t n, opcode_t o, logic [15:0] info);
        SB_msg_t m;
        m.msg_num  = n;
        m.opcode   = o;
        m.msg_info = info;
        return m;
    endfunction

    task automatic pulse(input logic [N-1:0] mask);
        req_valid = mask;
        step();
        req_valid = '0;
    endtask

    // Wait (bounded) for an issue, check it, then act as a serializer for 3 busy cycles
    task automatic serve(input string tag, input int idx, input SB_msg_t em, input logic [63:0] ed);
        int n;
        n = 0;
        while (tx_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, 64'(tx_valid), 64'd1);
        chk({tag, "_msg"}, 64'(tx_msg), 64'(em));
        chk({tag, "_data"}, tx_data, ed);
        step();
        flag = 1'b0;
        step();
        step();
        step();
        flag = 1'b1;
        #1;
        chk({tag, "_done"}, 64'(done), 64'(1 << idx));
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b1;
        flush     = 1'b0;
        flag      = 1'b1;
        req_msg   = '0;
        req_data  = '0;
        req_valid = '0;
        m0 = mk(SBINIT_done_req,            OPC_MSG_NODATA, 16'h0A00);
        m1 = mk(SBINIT_out_of_reset,        OPC_MSG_NODATA, 16'h0001);
        m2 = mk(MBINIT_PARAM_config_req,    OPC_MSG_DATA,   16'h0A02);
        m3 = mk(MBTRAIN_VALVREF_start_req,  OPC_MSG_NODATA, 16'h0A03);
        mb = mk(MBINIT_PARAM_config_resp,   OPC_MSG_DATA,   16'h0B0B);
        mc = mk(SBINIT_done_resp,           OPC_MSG_NODATA, 16'h0C0C);
        mt = mk(MBTRAIN_VALVREF_start_resp, OPC_MSG_DATA,   16'h7777);

        do_reset();
        chk("rst_valid",   64'(tx_valid), 64'd0);
        chk("rst_pending", 64'(pending),  64'd0);
        chk("rst_done",    64'(done),     64'd0);
        chk("rst_ovw",     64'(ovw),      64'd0);
        chk("rst_timeout", 64'(timeout),  64'd0);
        chk("rst_msg",     64'(tx_msg),   64'(reset_SB_msg()));
        chk("rst_data",    tx_data,       64'd0);

        // Single request: issue 2 cycles after the pulse, done when flag rises
        req_msg[1]  = m1;
        req_data[1] = 64'h1111_2222_3333_4444;
        pulse(4'b0010);
        chk("single_pend_t1",  64'(pending),  64'b0010);
        chk("single_valid_t1", 64'(tx_valid), 64'd0);
        step();
        chk("single_valid_t2", 64'(tx_valid), 64'd1);
        chk("single_msg",      64'(tx_msg),   64'(m1));
        chk("single_data",     tx_data,       64'h1111_2222_3333_4444);
        step();
        flag = 1'b0;
        chk("single_valid_1cyc", 64'(tx_valid), 64'd0);
        chk("single_pend_busy",  64'(pending),  64'b0010);
        repeat (9) step();
        chk("single_nodone_early", 64'(done), 64'd0);
        step();
        flag = 1'b1;
        #1;
        chk("single_done", 64'(done), 64'b0010);
        step();
        chk("single_done_1cyc", 64'(done),    64'd0);
        chk("single_pend_clr",  64'(pending), 64'd0);
        chk("single_hold_msg",  64'(tx_msg),  64'(m1));

        // Fairness from rr_ptr = 0
        do_reset();
        req_msg  = {m3, m2, m1, m0};
        req_data = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
        pulse(4'b1111);
        chk("fair_pend_all", 64'(pending), 64'b1111);
        serve("fair0", 0, m0, 64'hA0);
        serve("fair1", 1, m1, 64'hA1);
        serve("fair2", 2, m2, 64'hA2);
        serve("fair3", 3, m3, 64'hA3);
        req_data[0] = 64'hB0;
        req_data[2] = 64'hB2;
        pulse(4'b0101);
        serve("fair0b", 0, m0, 64'hB0);
        serve("fair2b", 2, m2, 64'hB2);

        // Overwrite: req 2 pulsed twice while req 0 is in flight
        req_data[0] = 64'hC0;
        pulse(4'b0001);
        step();
        chk("ovw_issue0", 64'(tx_msg), 64'(m0));
        step();
        flag        = 1'b0;
        req_msg[2]  = mb;
        req_data[2] = 64'hBBBB;
        req_valid   = 4'b0100;
        step();
        req_msg[2]  = mc;
        req_data[2] = 64'hCCCC;
        req_valid   = 4'b0100;
        chk("ovw_first_none", 64'(ovw), 64'd0);
        step();
        req_valid = '0;
        chk("ovw_pulse", 64'(ovw), 64'b0100);
        step();
        chk("ovw_once", 64'(ovw), 64'd0);
        flag = 1'b1;
        #1;
        chk("ovw_done0", 64'(done), 64'b0001);
        step();
        serve("ovw2", 2, mc, 64'hCCCC);

        // Accept timeout: flag never drops
        req_msg[3]  = mt;
        req_data[3] = 64'hDEAD_BEEF_0000_0003;
        pulse(4'b1000);
        step();
        chk("to_issue", 64'(tx_valid), 64'd1);
        repeat (8) step();
        chk("to_pend_inflight", 64'(pending), 64'b1000);
        repeat (7) step();
        chk("to_not_yet", 64'(timeout), 64'd0);
        step();
        chk("to_pulse",     64'(timeout),  64'd1);
        chk("to_restored",  64'(pending),  64'b1000);
        chk("to_no_valid",  64'(tx_valid), 64'd0);
        step();
        chk("to_reissue",       64'(tx_valid), 64'd1);
        chk("to_reissue_msg",   64'(tx_msg),   64'(mt));
        chk("to_reissue_data",  tx_data,       64'hDEAD_BEEF_0000_0003);
        chk("to_pulse_1cyc",    64'(timeout),  64'd0);
        step();
        flag = 1'b0;
        step();
        step();
        flag = 1'b1;
        #1;
        chk("to_done3", 64'(done), 64'b1000);
        step();

        // Enable low holds slots; flush empties them
        enable = 1'b0;
        pulse(4'b1010);
        chk("en_pend", 64'(pending), 64'b1010);
        step();
        step();
        chk("en_no_valid", 64'(tx_valid), 64'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_pend", 64'(pending), 64'd0);
        enable = 1'b1;
        step();
        step();
        step();
        chk("flush_no_valid", 64'(tx_valid), 64'd0);

        // Reset while in WAIT_DONE
        req_data[2] = 64'hE2;
        pulse(4'b0100);
        step();
        chk("rstmid_issue", 64'(tx_valid), 64'd1);
        step();
        flag = 1'b0;
        step();
        step();
        reset = 1'b1;
        flag  = 1'b1;
        #1;
        chk("rstmid_no_done", 64'(done), 64'd0);
        step();
        reset = 1'b0;
        chk("rstmid_pend",  64'(pending), 64'd0);
        chk("rstmid_valid", 64'(tx_valid), 64'd0);
        chk("rstmid_msg",   64'(tx_msg),  64'(reset_SB_msg()));
        chk("rstmid_data",  tx_data,      64'd0);
        chk("rstmid_done",  64'(done),    64'd0);
        req_data[1] = 64'hF1;
        req_data[3] = 64'hF3;
        pulse(4'b1010);
        serve("post1", 1, m1, 64'hF1);
        serve("post3", 3, mt, 64'hF3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
